itlb_ctrl: RTL and testbench
============================

# itlb_ctrl

Instruction micro-TLB controller between the pre-IF stage and the shared TLB search port 0. It translates the fetch address, keeps a one-entry micro-TLB, and sequences a TLB lookup on a miss. It gates the request to the instruction cache and raises TLB refill/invalid exceptions toward pre-IF. Unmapped kseg0/kseg1 fetches pass through with zero added latency.

## Interface
Parameters:
- `CNT_W`, 32: width of the hit and miss performance counters.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  pre-IF wants to issue a fetch this cycle (fs_allowin)
- `vaddr`  in  32  fetch virtual address (nextpc)
- `asid`  in  8  current ASID (EntryHi[7:0])
- `flush`  in  1  pipeline reflush; aborts an in-flight fill
- `tlb_write`  in  1  TLBWI/TLBWR committing this cycle
- `s0_vpn2`  out  19  search VPN2
- `s0_odd_page`  out  1  search odd-page select
- `s0_asid`  out  8  search ASID
- `s0_found`  in  1  search hit
- `s0_pfn`  in  20  PFN result
- `s0_c`  in  3  cache attribute result
- `s0_v`  in  1  valid bit result
- `cache_valid`  out  1  instruction-cache request valid
- `cache_paddr`  out  32  physical fetch address
- `cache_uncache`  out  1  1 = uncached
- `cache_addr_ok`  in  1  cache accepted the request
- `exc_valid`  out  1  fetch takes a TLB exception; the cache is not requested
- `exc_refill`  out  1  TLB refill, exception code 2
- `exc_invalid`  out  1  TLB invalid, exception code 2
- `busy`  out  1  FILL in progress
- `hit_cnt`  out  CNT_W  accepted mapped fetches that hit the micro-TLB
- `miss_cnt`  out  CNT_W  fills started

## Operation
- **Mapped test:** mapped = ~(vaddr[31] & ~vaddr[30]).
- **Unmapped fetch:**
  - paddr = {3'b0, vaddr[28:0]}.
  - uncache = (vaddr[31:29] == 3'b101).
- **Micro-TLB entry:** registers `e_valid`, `vpn2`, `odd`, `asid`, `pfn`, `c`, `v`, `found`.
- **Hit:** hit = e_valid & ~tlb_write & vpn2 == vaddr[31:13] & odd == vaddr[12] & asid match.
- **Mapped translation:**
  - paddr = {pfn, vaddr[11:0]}.
  - uncache = (c == 3'd2).
- **FSM states:** IDLE, FILL.
- **In IDLE:**
  - If req_valid & (~mapped | (hit & found & v)): cache_valid = 1.
  - If req_valid & mapped & hit & ~found: exc_valid = 1 and exc_refill = 1.
  - If req_valid & mapped & hit & found & ~v: exc_valid = 1 and exc_invalid = 1.
  - If req_valid & mapped & ~hit & ~tlb_write: latch vaddr[31:12] and asid into the fill registers, increment `miss_cnt`, go to FILL.
- **In FILL:**
  - `s0_*` are driven from the fill registers.
  - cache_valid = 0 and exc_valid = 0.
  - Next state is always IDLE.
  - The entry is written from the `s0_*` results with e_valid = 1, unless flush or tlb_write is high that cycle. In that case nothing is written.
- **tlb_write:** clears e_valid in any state.
- **hit_cnt:** increments on cache_valid & cache_addr_ok & mapped.
- **Counters:** both wrap modulo 2^CNT_W.
- **Request hold:** while cache_valid is high without cache_addr_ok, the request is combinational. It therefore follows vaddr; pre-IF holds or changes vaddr by its own rules.

## Timing
- **Reset values:**
  - state IDLE, e_valid 0, fill registers 0, so `s0_*` = 0.
  - cache_valid 0 (gated by reset), exc_valid/exc_refill/exc_invalid 0, busy 0, counters 0.
- **Latency:**
  - Unmapped fetch or micro-TLB hit: cache_valid in the same cycle as req_valid.
  - Miss: cycle 0 detects the miss, cycle 1 is FILL, cycle 2 is IDLE with a hit, so cache_valid is asserted 2 cycles after req_valid.
- **TLB search:** combinational; results are sampled at the end of the FILL cycle.
- **Simultaneous events:**
  - tlb_write in the same cycle as an IDLE lookup: forced miss, and no FILL starts that cycle.
  - flush in IDLE does not suppress the request; the new vaddr is evaluated normally.
- **busy:** equals (state == FILL).
- **Exceptions:** exc_valid is combinational. It stays high while the condition holds, and pre-IF consumes it without a handshake.

## Structure
- `mycpu.h` gains:
  - `EXC_TLBL`  5'h2
  - `EXC_ADEL`  5'h4
  - `EXC_NONE`  5'h9
  - `ITLB_IDLE` / `ITLB_FILL` state encodings
- No sub-module. The micro-TLB entry is inline registers.
- pre-IF instantiates `itlb_ctrl`. pre-IF ORs exc_valid into its exception path and uses exc_refill for the refill-vector bit.

## Test plan
- **Unmapped cached:** vaddr=0x80001234, req_valid=1 -> same-cycle cache_valid=1, cache_paddr=0x00001234, cache_uncache=0.
- **Unmapped uncached:** vaddr=0xBFC00000 -> cache_paddr=0x1FC00000, cache_uncache=1.
- **Mapped miss then hit:** vaddr=0x00403008, asid=5, TLB returns found=1, pfn=0x12345, v=1, c=3.
  - cycle 1: busy=1.
  - cycle 2: cache_valid=1, cache_paddr=0x12345008, cache_uncache=0.
  - miss_cnt=1, and hit_cnt=1 after addr_ok.
- **Refill and invalid exceptions:**
  - found=0 -> after FILL, exc_valid=1, exc_refill=1, cache_valid=0.
  - found=1, v=0 -> exc_valid=1, exc_invalid=1.
- **tlb_write handling:**
  - tlb_write during an IDLE hit -> no cache_valid that cycle; next access misses.
  - tlb_write during FILL -> entry not written; following cycle misses again.
- **Mid-fill events:**
  - flush during FILL -> return to IDLE, e_valid stays 0.
  - reset asserted during FILL -> IDLE, all outputs at reset values next cycle.

Source files
------------

// File: rtl/itlb_ctrl_pkg.sv
// Shared definitions for the instruction micro-TLB controller: exception codes,
// FSM encoding, the micro-TLB entry layout and the address-segment test.
package itlb_ctrl_pkg;

  localparam logic [4:0] EXC_TLBL = 5'h2;
  localparam logic [4:0] EXC_ADEL = 5'h4;
  localparam logic [4:0] EXC_NONE = 5'h9;

  typedef enum logic {
    ITLB_IDLE = 1'b0,
    ITLB_FILL = 1'b1
  } itlb_state_t;

  typedef struct packed {
    logic        valid;
    logic [18:0] vpn2;
    logic        odd;
    logic [7:0]  asid;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        v;
    logic        found;
  } utlb_entry_t;

  // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) bypass translation.
  function automatic logic is_mapped(input logic [31:0] va);
    return ~(va[31] & ~va[30]);
  endfunction

endpackage

// File: rtl/itlb_ctrl.sv
// Instruction micro-TLB controller: one-entry uTLB in front of TLB search port 0,
// gating the I-cache request and raising TLB refill/invalid exceptions to pre-IF.
module itlb_ctrl
  import itlb_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [31:0]      vaddr,
  input  logic [7:0]       asid,
  input  logic             flush,
  input  logic             tlb_write,
  output logic [18:0]      s0_vpn2,
  output logic             s0_odd_page,
  output logic [7:0]       s0_asid,
  input  logic             s0_found,
  input  logic [19:0]      s0_pfn,
  input  logic [2:0]       s0_c,
  input  logic             s0_v,
  output logic             cache_valid,
  output logic [31:0]      cache_paddr,
  output logic             cache_uncache,
  input  logic             cache_addr_ok,
  output logic             exc_valid,
  output logic             exc_refill,
  output logic             exc_invalid,
  output logic             busy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  itlb_state_t r_state;
  itlb_state_t w_state_next;
  utlb_entry_t r_entry;
  logic [19:0] r_fill_vpn;
  logic [7:0]  r_fill_asid;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic w_mapped;
  logic w_hit;
  logic w_start_fill;
  logic w_fill_write;

  assign w_mapped = is_mapped(vaddr);

  // A TLB write in flight invalidates the entry, so it must not hit this cycle either.
  assign w_hit = r_entry.valid & ~tlb_write
               & (r_entry.vpn2 == vaddr[31:13])
               & (r_entry.odd == vaddr[12])
               & (r_entry.asid == asid);

  assign s0_vpn2     = r_fill_vpn[19:1];
  assign s0_odd_page = r_fill_vpn[0];
  assign s0_asid     = r_fill_asid;

  assign cache_paddr   = w_mapped ? {r_entry.pfn, vaddr[11:0]} : {3'b000, vaddr[28:0]};
  assign cache_uncache = w_mapped ? (r_entry.c == 3'd2) : (vaddr[31:29] == 3'b101);

  assign busy     = (r_state == ITLB_FILL);
  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;

  assign w_fill_write = (r_state == ITLB_FILL) & ~flush & ~tlb_write;

  always_comb begin
    w_state_next = r_state;
    cache_valid  = 1'b0;
    exc_valid    = 1'b0;
    exc_refill   = 1'b0;
    exc_invalid  = 1'b0;
    w_start_fill = 1'b0;
    case (r_state)
      ITLB_IDLE: begin
        if (req_valid & ~reset) begin
          if (~w_mapped) begin
            cache_valid = 1'b1;
          end else if (w_hit) begin
            if (r_entry.found & r_entry.v) begin
              cache_valid = 1'b1;
            end else if (~r_entry.found) begin
              exc_valid  = 1'b1;
              exc_refill = 1'b1;
            end else begin
              exc_valid   = 1'b1;
              exc_invalid = 1'b1;
            end
          end else if (~tlb_write) begin
            w_start_fill = 1'b1;
            w_state_next = ITLB_FILL;
          end
        end
      end
      ITLB_FILL: begin
        w_state_next = ITLB_IDLE;
      end
      default: begin
        w_state_next = ITLB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ITLB_IDLE;
      r_entry     <= '0;
      r_fill_vpn  <= '0;
      r_fill_asid <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_fill) begin
        r_fill_vpn  <= vaddr[31:12];
        r_fill_asid <= asid;
        r_miss_cnt  <= r_miss_cnt + CNT_W'(1);
      end
      // Search results are captured at the end of FILL, even a not-found one,
      // so the following IDLE cycle turns it into a refill exception.
      if (w_fill_write) begin
        r_entry.valid <= 1'b1;
        r_entry.vpn2  <= r_fill_vpn[19:1];
        r_entry.odd   <= r_fill_vpn[0];
        r_entry.asid  <= r_fill_asid;
        r_entry.pfn   <= s0_pfn;
        r_entry.c     <= s0_c;
        r_entry.v     <= s0_v;
        r_entry.found <= s0_found;
      end
      if (tlb_write) begin
        r_entry.valid <= 1'b0;
      end
      if (cache_valid & cache_addr_ok & w_mapped) begin
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_itlb_ctrl.sv
// Self-checking bench for itlb_ctrl: directed scenarios plus a randomized run
// compared against a cycle-level reference model and a small mock TLB.
module tb_itlb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] vaddr;
  logic [7:0]  asid;
  logic        flush;
  logic        tlb_write;
  logic [18:0] s0_vpn2;
  logic        s0_odd_page;
  logic [7:0]  s0_asid;
  logic        s0_found;
  logic [19:0] s0_pfn;
  logic [2:0]  s0_c;
  logic        s0_v;
  logic        cache_valid;
  logic [31:0] cache_paddr;
  logic        cache_uncache;
  logic        cache_addr_ok;
  logic        exc_valid;
  logic        exc_refill;
  logic        exc_invalid;
  logic        busy;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  itlb_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .vaddr(vaddr), .asid(asid),
    .flush(flush), .tlb_write(tlb_write),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_v(s0_v),
    .cache_valid(cache_valid), .cache_paddr(cache_paddr), .cache_uncache(cache_uncache),
    .cache_addr_ok(cache_addr_ok), .exc_valid(exc_valid), .exc_refill(exc_refill),
    .exc_invalid(exc_invalid), .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Mock shared TLB: four entries, each an even/odd page pair.
  logic [18:0] t_vpn  [4];
  logic [7:0]  t_asid [4];
  logic [19:0] t_pfn  [4][2];
  logic [2:0]  t_c    [4][2];
  logic        t_v    [4][2];

  always_comb begin
    s0_found = 1'b0;
    s0_pfn   = '0;
    s0_c     = '0;
    s0_v     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (t_vpn[k] == s0_vpn2 && t_asid[k] == s0_asid) begin
        s0_found = 1'b1;
        s0_pfn   = t_pfn[k][s0_odd_page];
        s0_c     = t_c[k][s0_odd_page];
        s0_v     = t_v[k][s0_odd_page];
      end
    end
  end

  function automatic void tlb_lookup(input logic [19:0] vpn, input logic [7:0] as,
                                     output logic f, output logic [19:0] p,
                                     output logic [2:0] c, output logic v);
    f = 1'b0; p = '0; c = '0; v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (t_vpn[k] == vpn[19:1] && t_asid[k] == as) begin
        f = 1'b1;
        p = t_pfn[k][vpn[0]];
        c = t_c[k][vpn[0]];
        v = t_v[k][vpn[0]];
      end
    end
  endfunction

  task automatic apply(input logic rv, input logic [31:0] va, input logic [7:0] as,
                       input logic fl, input logic tw, input logic aok);
    @(negedge clk);
    req_valid = rv; vaddr = va; asid = as; flush = fl; tlb_write = tw; cache_addr_ok = aok;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(1'b1, 32'h8000_0000, 8'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (cache_valid !== 1'b0) begin
      errors++; $display("FAIL reset_gate cache_valid got %b want 0", cache_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    apply(1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0 || exc_valid !== 1'b0) begin
      errors++; $display("FAIL reset_state busy=%b hit=%0d miss=%0d exc=%b want 0/0/0/0",
                         busy, hit_cnt, miss_cnt, exc_valid);
    end
    checks++;
    if ({s0_vpn2, s0_odd_page, s0_asid} !== 28'd0) begin
      errors++; $display("FAIL reset_s0 got %h want 0", {s0_vpn2, s0_odd_page, s0_asid});
    end
    $display("txn reset done");
  endtask

  task automatic test_unmapped();
    apply(1'b1, 32'h8000_1234, 8'd5, 1'b0, 1'b0, 1'b1);
    checks++;
    if (cache_valid !== 1'b1 || cache_paddr !== 32'h0000_1234 || cache_uncache !== 1'b0) begin
      errors++; $display("FAIL unmapped_cached cv=%b pa=%h unc=%b want 1/00001234/0",
                         cache_valid, cache_paddr, cache_uncache);
    end
    apply(1'b1, 32'hBFC0_0000, 8'd5, 1'b0, 1'b0, 1'b1);
    checks++;
    if (cache_valid !== 1'b1 || cache_paddr !== 32'h1FC0_0000 || cache_uncache !== 1'b1) begin
      errors++; $display("FAIL unmapped_uncached cv=%b pa=%h unc=%b want 1/1fc00000/1",
                         cache_valid, cache_paddr, cache_uncache);
    end
    apply(1'b0, 32'h0, 8'd5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hit_cnt !== 32'd0) begin
      errors++; $display("FAIL unmapped_no_hitcnt got %0d want 0", hit_cnt);
    end
    $display("txn unmapped done");
  endtask

  task automatic test_miss_hit();
    apply(1'b1, 32'h0040_3008, 8'd5, 1'b0, 1'b0, 1'b1);
    checks++;
    if (cache_valid !== 1'b0 || busy !== 1'b0 || exc_valid !== 1'b0) begin
      errors++; $display("FAIL miss_c0 cv=%b busy=%b exc=%b want 0/0/0", cache_valid, busy, exc_valid);
    end
    apply(1'b1, 32'h0040_3008, 8'd5, 1'b0, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b1 || cache_valid !== 1'b0 || s0_vpn2 !== 19'h201 || s0_odd_page !== 1'b1
        || s0_asid !== 8'd5 || miss_cnt !== 32'd1) begin
      errors++; $display("FAIL miss_fill busy=%b cv=%b vpn=%h odd=%b asid=%0d miss=%0d want 1/0/201/1/5/1",
                         busy, cache_valid, s0_vpn2, s0_odd_page, s0_asid, miss_cnt);
    end
    apply(1'b1, 32'h0040_3008, 8'd5, 1'b0, 1'b0, 1'b1);
    checks++;
    if (cache_valid !== 1'b1 || cache_paddr !== 32'h1234_5008 || cache_uncache !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL miss_then_hit cv=%b pa=%h unc=%b busy=%b want 1/12345008/0/0",
                         cache_valid, cache_paddr, cache_uncache, busy);
    end
    apply(1'b0, 32'h0, 8'd5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      errors++; $display("FAIL miss_hit_counts hit=%0d miss=%0d want 1/1", hit_cnt, miss_cnt);
    end
    $display("txn miss_hit done");
  endtask

  task automatic test_exceptions();
    repeat (2) apply(1'b1, 32'h0080_0000, 8'd5, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 32'h0080_0000, 8'd5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (exc_valid !== 1'b1 || exc_refill !== 1'b1 || exc_invalid !== 1'b0 || cache_valid !== 1'b0) begin
      errors++; $display("FAIL exc_refill exc=%b ref=%b inv=%b cv=%b want 1/1/0/0",
                         exc_valid, exc_refill, exc_invalid, cache_valid);
    end
    repeat (2) apply(1'b1, 32'h00C0_0000, 8'd5, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 32'h00C0_0000, 8'd5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (exc_valid !== 1'b1 || exc_refill !== 1'b0 || exc_invalid !== 1'b1 || cache_valid !== 1'b0) begin
      errors++; $display("FAIL exc_invalid exc=%b ref=%b inv=%b cv=%b want 1/0/1/0",
                         exc_valid, exc_refill, exc_invalid, cache_valid);
    end
    checks++;
    if (miss_cnt !== 32'd3) begin
      errors++; $display("FAIL exc_misscnt got %0d want 3", miss_cnt);
    end
    $display("txn exceptions done");
  endtask

  task automatic test_tlb_write();
    logic [31:0] va;
    va = 32'h0040_3008;
    repeat (2) apply(1'b1, va, 8'd5, 1'b0, 1'b0, 1'b0);
    apply(1'b1, va, 8'd5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cache_valid !== 1'b1) begin
      errors++; $display("FAIL tw_prehit cv=%b want 1", cache_valid);
    end
    apply(1'b1, va, 8'd5, 1'b0, 1'b1, 1'b0);
    checks++;
    if (cache_valid !== 1'b0 || exc_valid !== 1'b0) begin
      errors++; $display("FAIL tw_idle_hit cv=%b exc=%b want 0/0", cache_valid, exc_valid);
    end
    apply(1'b1, va, 8'd5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || cache_valid !== 1'b0) begin
      errors++; $display("FAIL tw_next_miss busy=%b cv=%b want 0/0", busy, cache_valid);
    end
    apply(1'b1, va, 8'd5, 1'b0, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL tw_fill_busy got %b want 1", busy);
    end
    apply(1'b1, va, 8'd5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || cache_valid !== 1'b0) begin
      errors++; $display("FAIL tw_fill_nowrite busy=%b cv=%b want 0/0", busy, cache_valid);
    end
    apply(1'b1, va, 8'd5, 1'b0, 1'b0, 1'b0);
    apply(1'b1, va, 8'd5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cache_valid !== 1'b1 || cache_paddr !== 32'h1234_5008) begin
      errors++; $display("FAIL tw_refill_hit cv=%b pa=%h want 1/12345008", cache_valid, cache_paddr);
    end
    $display("txn tlb_write done");
  endtask

  task automatic test_flush_fill();
    logic [31:0] va;
    va = 32'h0040_3008;
    apply(1'b0, va, 8'd5, 1'b0, 1'b1, 1'b0);
    apply(1'b1, va, 8'd5, 1'b0, 1'b0, 1'b0);
    apply(1'b1, va, 8'd5, 1'b1, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL flush_fill_busy got %b want 1", busy);
    end
    apply(1'b1, va, 8'd5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || cache_valid !== 1'b0 || exc_valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_write busy=%b cv=%b exc=%b want 0/0/0", busy, cache_valid, exc_valid);
    end
    apply(1'b1, va, 8'd5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL flush_refill_busy got %b want 1", busy);
    end
    $display("txn flush_fill done");
  endtask

  task automatic test_reset_fill();
    logic [31:0] va;
    va = 32'h0040_3008;
    apply(1'b0, va, 8'd5, 1'b0, 1'b1, 1'b0);
    apply(1'b1, va, 8'd5, 1'b0, 1'b0, 1'b0);
    apply(1'b1, va, 8'd5, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    apply(1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0 || cache_valid !== 1'b0
        || exc_valid !== 1'b0 || {s0_vpn2, s0_odd_page, s0_asid} !== 28'd0) begin
      errors++; $display("FAIL reset_in_fill busy=%b hit=%0d miss=%0d cv=%b exc=%b s0=%h want all 0",
                         busy, hit_cnt, miss_cnt, cache_valid, exc_valid, {s0_vpn2, s0_odd_page, s0_asid});
    end
    apply(1'b1, va, 8'd5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cache_valid !== 1'b0) begin
      errors++; $display("FAIL reset_fill_miss cv=%b want 0", cache_valid);
    end
    $display("txn reset_fill done");
  endtask

  task automatic test_random();
    logic [18:0] pick [5];
    logic        m_busy, m_ev, m_odd, m_found, m_v;
    logic [18:0] m_vpn;
    logic [7:0]  m_asid, m_fill_asid;
    logic [19:0] m_pfn, m_fill;
    logic [2:0]  m_c;
    logic [31:0] m_hit, m_miss;
    logic [31:0] va, exp_pa;
    logic [7:0]  as;
    logic        rv, fl, tw, aok, mapped, hit;
    logic        e_cv, e_exc, e_ref, e_inv, e_unc;
    logic        lf, lv;
    logic [19:0] lp;
    logic [2:0]  lc;
    int          sel;
    pick[0] = 19'h00201; pick[1] = 19'h00600; pick[2] = 19'h60000;
    pick[3] = 19'h007FF; pick[4] = 19'h00400;
    reset = 1'b1;
    apply(1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_busy = 0; m_ev = 0; m_odd = 0; m_found = 0; m_v = 0; m_vpn = '0; m_asid = '0;
    m_pfn = '0; m_c = '0; m_fill = '0; m_fill_asid = '0; m_hit = 0; m_miss = 0;
    va = 32'h0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        sel = $urandom_range(0, 6);
        if (sel == 5)      va = {3'b100, 29'($urandom)};
        else if (sel == 6) va = {3'b101, 29'($urandom)};
        else               va = {pick[sel], 1'($urandom), 12'($urandom)};
      end
      as  = ($urandom_range(0, 3) == 0) ? 8'd6 : 8'd5;
      rv  = ($urandom_range(0, 9) < 8);
      fl  = ($urandom_range(0, 9) == 0);
      tw  = ($urandom_range(0, 19) == 0);
      aok = ($urandom_range(0, 9) < 7);
      apply(rv, va, as, fl, tw, aok);

      // Expected outputs from the current model state.
      mapped = !(va[31] == 1'b1 && va[30] == 1'b0);
      hit = m_ev && !tw && m_vpn == va[31:13] && m_odd == va[12] && m_asid == as;
      e_cv = 0; e_exc = 0; e_ref = 0; e_inv = 0; exp_pa = 32'h0; e_unc = 0;
      if (!m_busy && rv) begin
        if (!mapped) begin
          e_cv = 1; exp_pa = va & 32'h1FFF_FFFF; e_unc = (va[31:29] == 3'b101);
        end else if (hit) begin
          if (!m_found)  begin e_exc = 1; e_ref = 1; end
          else if (!m_v) begin e_exc = 1; e_inv = 1; end
          else begin e_cv = 1; exp_pa = {m_pfn, va[11:0]}; e_unc = (m_c == 3'd2); end
        end
      end
      checks++;
      if (cache_valid !== e_cv || exc_valid !== e_exc || exc_refill !== e_ref || exc_invalid !== e_inv) begin
        errors++; $display("FAIL rnd_ctrl n=%0d va=%h cv/exc/ref/inv got %b%b%b%b want %b%b%b%b",
                           n, va, cache_valid, exc_valid, exc_refill, exc_invalid, e_cv, e_exc, e_ref, e_inv);
      end
      if (e_cv) begin
        checks++;
        if (cache_paddr !== exp_pa || cache_uncache !== e_unc) begin
          errors++; $display("FAIL rnd_paddr n=%0d va=%h got %h/%b want %h/%b",
                             n, va, cache_paddr, cache_uncache, exp_pa, e_unc);
        end
      end
      checks++;
      if (busy !== m_busy || hit_cnt !== m_hit || miss_cnt !== m_miss
          || {s0_vpn2, s0_odd_page} !== m_fill || s0_asid !== m_fill_asid) begin
        errors++; $display("FAIL rnd_state n=%0d busy=%b hit=%0d miss=%0d s0=%h/%0d want %b/%0d/%0d/%h/%0d",
                           n, busy, hit_cnt, miss_cnt, {s0_vpn2, s0_odd_page}, s0_asid,
                           m_busy, m_hit, m_miss, m_fill, m_fill_asid);
      end
      if (e_cv && aok) $display("txn %0d fetch va=%h pa=%h unc=%b", n, va, exp_pa, e_unc);

      // Advance the model across the coming clock edge.
      if (e_cv && aok && mapped) m_hit = m_hit + 1;
      if (m_busy) begin
        if (!fl && !tw) begin
          tlb_lookup(m_fill, m_fill_asid, lf, lp, lc, lv);
          m_ev = 1; m_vpn = m_fill[19:1]; m_odd = m_fill[0]; m_asid = m_fill_asid;
          m_found = lf; m_pfn = lp; m_c = lc; m_v = lv;
        end
        m_busy = 0;
      end else if (rv && mapped && !hit && !tw) begin
        m_fill = va[31:12]; m_fill_asid = as; m_miss = m_miss + 1; m_busy = 1;
      end
      if (tw) m_ev = 0;
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 0; vaddr = 0; asid = 0; flush = 0; tlb_write = 0; cache_addr_ok = 0;
    t_vpn[0] = 19'h00201; t_asid[0] = 8'd5;
    t_pfn[0][0] = 20'h11111; t_c[0][0] = 3'd3; t_v[0][0] = 1'b1;
    t_pfn[0][1] = 20'h12345; t_c[0][1] = 3'd3; t_v[0][1] = 1'b1;
    t_vpn[1] = 19'h00600; t_asid[1] = 8'd5;
    t_pfn[1][0] = 20'h22222; t_c[1][0] = 3'd3; t_v[1][0] = 1'b0;
    t_pfn[1][1] = 20'h23456; t_c[1][1] = 3'd2; t_v[1][1] = 1'b1;
    t_vpn[2] = 19'h60000; t_asid[2] = 8'd6;
    t_pfn[2][0] = 20'h0ABCD; t_c[2][0] = 3'd2; t_v[2][0] = 1'b1;
    t_pfn[2][1] = 20'h0BCDE; t_c[2][1] = 3'd3; t_v[2][1] = 1'b0;
    t_vpn[3] = 19'h007FF; t_asid[3] = 8'd5;
    t_pfn[3][0] = 20'h33333; t_c[3][0] = 3'd3; t_v[3][0] = 1'b1;
    t_pfn[3][1] = 20'h34567; t_c[3][1] = 3'd3; t_v[3][1] = 1'b1;
    test_reset();
    test_unmapped();
    test_miss_hit();
    test_exceptions();
    test_tlb_write();
    test_flush_fill();
    test_reset_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
